ft60x_245fifo_emu: RTL

- Synthesizable model of the FT60x chip side of the 245-synchronous-FIFO interface.
- Responds to the FPGA-side FT60x driver's usb_rd_n, usb_wr_n and usb_oe_n strobes, and drives usb_rxf_n, usb_txe_n, data and byte enables back to it.
- The host side is modelled by two AXI-stream ports: a host-to-FPGA stream feeds the read buffer, and FPGA-to-host data exits on a master stream.
- Used for loopback simulation and on-board self-test without a USB host.

---
 rtl/ft60x_245fifo_emu_if.sv | 37 +++
 rtl/ft60x_245fifo_emu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ft60x_245fifo_emu_if.sv
// ---------------------------------------------------------------------------
// ft60x_245fifo_emu_if
// Bus bundle between an FPGA-side FT60x 245-sync-FIFO driver and the chip
// emulator.
//   master modport : the FPGA driver (drives strobes, write data/byte enables)
//   slave modport  : the emulated FT60x (drives flags, read data, tristate)
// Signals:
//   usb_wr_n / usb_rd_n / usb_oe_n : active-low strobes from the driver
//   usb_be_w / usb_data_w          : write byte enables / data from the driver
//   usb_txe_n / usb_rxf_n          : active-low "can write" / "has data" flags
//   usb_be_r / usb_data_r          : read byte enables / data to the driver
//   usb_drv_t                      : 0 = emulator drives the bus, 1 = high-Z
// ---------------------------------------------------------------------------
interface ft60x_245fifo_emu_if #(
    parameter int FIFO_BUS_WIDTH = 2
);
    logic                          usb_wr_n;
    logic                          usb_rd_n;
    logic                          usb_oe_n;
    logic [FIFO_BUS_WIDTH-1:0]     usb_be_w;
    logic [FIFO_BUS_WIDTH*8-1:0]   usb_data_w;
    logic                          usb_txe_n;
    logic                          usb_rxf_n;
    logic [FIFO_BUS_WIDTH-1:0]     usb_be_r;
    logic [FIFO_BUS_WIDTH*8-1:0]   usb_data_r;
    logic                          usb_drv_t;

    modport master (
        output usb_wr_n, usb_rd_n, usb_oe_n, usb_be_w, usb_data_w,
        input  usb_txe_n, usb_rxf_n, usb_be_r, usb_data_r, usb_drv_t
    );

    modport slave (
        input  usb_wr_n, usb_rd_n, usb_oe_n, usb_be_w, usb_data_w,
        output usb_txe_n, usb_rxf_n, usb_be_r, usb_data_r, usb_drv_t
    );
endinterface

// File: rtl/ft60x_245fifo_emu.sv
// ---------------------------------------------------------------------------
// ft60x_245fifo_emu
// Chip-side model of an FT60x in 245 synchronous FIFO mode, for loopback
// simulation and on-board self-test without a USB host.
//   usb_clk, rstn_usbclk : clock (rising edge) and asynchronous active-low reset
//   usb (slave)          : FT60x bus towards the FPGA driver
//   s_axis_*             : host-to-FPGA stream, feeds the read buffer
//   m_axis_*             : FPGA-to-host stream, drains the write buffer
//   overflow / underrun  : sticky error flags, cleared only by reset
// ---------------------------------------------------------------------------
module ft60x_245fifo_emu #(
    parameter int FIFO_BUS_WIDTH = 2,
    parameter int DEPTH_LOG2     = 4
) (
    input  logic                         usb_clk,
    input  logic                         rstn_usbclk,
    ft60x_245fifo_emu_if.slave           usb,
    input  logic [FIFO_BUS_WIDTH*8-1:0]  s_axis_tdata,
    input  logic [FIFO_BUS_WIDTH-1:0]    s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [FIFO_BUS_WIDTH*8-1:0]  m_axis_tdata,
    output logic [FIFO_BUS_WIDTH-1:0]    m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         overflow,
    output logic                         underrun
);
    localparam int BW    = FIFO_BUS_WIDTH;
    localparam int DW    = FIFO_BUS_WIDTH * 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0] ptr_t;
    localparam ptr_t DEPTH_P     = ptr_t'(DEPTH);
    localparam ptr_t TXE_LIMIT_P = ptr_t'(DEPTH - 3);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_OE   = 2'd1;
    localparam logic [1:0] R_READ = 2'd2;

    // ------------------------------------------------------------------
    // Read buffer (host -> FPGA), entries are {tkeep, tdata}
    // ------------------------------------------------------------------
    logic [BW+DW-1:0] rbuf_mem [DEPTH];
    ptr_t             rbuf_wr_ptr_reg, rbuf_rd_ptr_reg;
    ptr_t             rbuf_count, rbuf_count_next;
    logic             rbuf_empty, rbuf_full, rbuf_push, rbuf_pop;
    logic [BW+DW-1:0] rbuf_head;
    logic             s_axis_tready_reg, rxf_n_reg;
    logic [1:0]       rstate_reg, rstate_next;
    logic [DW-1:0]    data_last_reg;
    logic             show;
    logic             underrun_reg;

    assign rbuf_empty = (rbuf_wr_ptr_reg == rbuf_rd_ptr_reg);
    assign rbuf_full  = (rbuf_wr_ptr_reg[DEPTH_LOG2] != rbuf_rd_ptr_reg[DEPTH_LOG2]) &&
                        (rbuf_wr_ptr_reg[DEPTH_LOG2-1:0] == rbuf_rd_ptr_reg[DEPTH_LOG2-1:0]);
    assign rbuf_count = rbuf_wr_ptr_reg - rbuf_rd_ptr_reg;
    assign rbuf_head  = rbuf_mem[rbuf_rd_ptr_reg[DEPTH_LOG2-1:0]];

    // An accepted word with no byte enables carries nothing, so it is
    // handshaken but never stored.
    assign rbuf_push = s_axis_tvalid & s_axis_tready_reg & (|s_axis_tkeep) & ~rbuf_full;
    assign rbuf_pop  = (rstate_reg == R_READ) & ~usb.usb_rd_n & ~rbuf_empty;
    assign rbuf_count_next = rbuf_count + ptr_t'(rbuf_push) - ptr_t'(rbuf_pop);

    always_ff @(posedge usb_clk) begin
        if (rbuf_push)
            rbuf_mem[rbuf_wr_ptr_reg[DEPTH_LOG2-1:0]] <= {s_axis_tkeep, s_axis_tdata};
    end

    always_comb begin
        rstate_next = rstate_reg;
        if (usb.usb_oe_n)
            rstate_next = R_IDLE;
        else if (rstate_reg == R_IDLE)
            rstate_next = R_OE;
        else if (rstate_reg == R_OE && !usb.usb_rd_n)
            rstate_next = R_READ;
    end

    assign usb.usb_drv_t = (rstate_reg == R_IDLE);
    assign show          = ~usb.usb_drv_t & ~rbuf_empty;

    // Per-lane output mux: the head is shown while driving; otherwise the
    // data lanes keep the last shown value and the byte enables drop to 0.
    for (genvar gi = 0; gi < BW; gi++) begin : g_rd_lane
        assign usb.usb_be_r[gi] = show & rbuf_head[DW+gi];
        assign usb.usb_data_r[gi*8 +: 8] = show ? rbuf_head[gi*8 +: 8]
                                                : data_last_reg[gi*8 +: 8];
    end

    assign s_axis_tready  = s_axis_tready_reg;
    assign usb.usb_rxf_n  = rxf_n_reg;
    assign underrun       = underrun_reg;

    always_ff @(posedge usb_clk or negedge rstn_usbclk) begin
        if (!rstn_usbclk) begin
            rbuf_wr_ptr_reg   <= '0;
            rbuf_rd_ptr_reg   <= '0;
            s_axis_tready_reg <= 1'b0;
            rxf_n_reg         <= 1'b1;
            rstate_reg        <= R_IDLE;
            data_last_reg     <= '0;
            underrun_reg      <= 1'b0;
        end else begin
            if (rbuf_push) rbuf_wr_ptr_reg <= rbuf_wr_ptr_reg + 1'b1;
            if (rbuf_pop)  rbuf_rd_ptr_reg <= rbuf_rd_ptr_reg + 1'b1;
            s_axis_tready_reg <= (rbuf_count_next < DEPTH_P);
            rxf_n_reg         <= (rbuf_count_next == '0);
            rstate_reg        <= rstate_next;
            if (show) data_last_reg <= rbuf_head[DW-1:0];
            if (!usb.usb_rd_n && rbuf_empty) underrun_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write path (FPGA -> host): capture register, then buffer of
    // {tlast, tkeep, tdata}
    // ------------------------------------------------------------------
    logic [1+BW+DW-1:0] wbuf_mem [DEPTH];
    ptr_t               wbuf_wr_ptr_reg, wbuf_rd_ptr_reg;
    ptr_t               wbuf_count, wbuf_count_next;
    logic               wbuf_empty, wbuf_full, wbuf_push, wbuf_pop, wbuf_room;
    logic [1+BW+DW-1:0] wbuf_head;
    logic               capture;
    logic               pipe_valid_reg;
    logic [BW-1:0]      pipe_be_reg;
    logic [DW-1:0]      pipe_data_reg;
    logic               txe_n_reg, overflow_reg;

    assign wbuf_empty = (wbuf_wr_ptr_reg == wbuf_rd_ptr_reg);
    assign wbuf_full  = (wbuf_wr_ptr_reg[DEPTH_LOG2] != wbuf_rd_ptr_reg[DEPTH_LOG2]) &&
                        (wbuf_wr_ptr_reg[DEPTH_LOG2-1:0] == wbuf_rd_ptr_reg[DEPTH_LOG2-1:0]);
    assign wbuf_count = wbuf_wr_ptr_reg - wbuf_rd_ptr_reg;
    assign wbuf_head  = wbuf_mem[wbuf_rd_ptr_reg[DEPTH_LOG2-1:0]];

    // txe_n is only advice to the driver: a strobe that arrives after it
    // rose (the driver reacts one cycle late) is still taken, and the
    // three-entry margin below is what absorbs it.
    assign capture   = ~usb.usb_wr_n & (|usb.usb_be_w);
    assign wbuf_pop  = ~wbuf_empty & m_axis_tready;
    assign wbuf_room = ~wbuf_full | wbuf_pop;
    assign wbuf_push = pipe_valid_reg & wbuf_room;
    assign wbuf_count_next = wbuf_count + ptr_t'(wbuf_push) - ptr_t'(wbuf_pop);

    // The word in the capture register ends a burst when nothing follows it.
    always_ff @(posedge usb_clk) begin
        if (wbuf_push)
            wbuf_mem[wbuf_wr_ptr_reg[DEPTH_LOG2-1:0]] <= {~capture, pipe_be_reg, pipe_data_reg};
    end

    assign m_axis_tvalid = ~wbuf_empty;
    assign m_axis_tlast  = ~wbuf_empty & wbuf_head[BW+DW];
    assign m_axis_tkeep  = wbuf_head[DW +: BW];
    assign m_axis_tdata  = wbuf_head[DW-1:0];
    assign usb.usb_txe_n = txe_n_reg;
    assign overflow      = overflow_reg;

    always_ff @(posedge usb_clk or negedge rstn_usbclk) begin
        if (!rstn_usbclk) begin
            wbuf_wr_ptr_reg <= '0;
            wbuf_rd_ptr_reg <= '0;
            pipe_valid_reg  <= 1'b0;
            pipe_be_reg     <= '0;
            pipe_data_reg   <= '0;
            txe_n_reg       <= 1'b1;
            overflow_reg    <= 1'b0;
        end else begin
            if (wbuf_push) wbuf_wr_ptr_reg <= wbuf_wr_ptr_reg + 1'b1;
            if (wbuf_pop)  wbuf_rd_ptr_reg <= wbuf_rd_ptr_reg + 1'b1;
            pipe_valid_reg <= capture;
            if (capture) begin
                pipe_be_reg   <= usb.usb_be_w;
                pipe_data_reg <= usb.usb_data_w;
            end
            // Fewer than three free entries left after this edge.
            txe_n_reg <= (wbuf_count_next > TXE_LIMIT_P);
            if (pipe_valid_reg && !wbuf_room) overflow_reg <= 1'b1;
        end
    end
endmodule
